// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - Segment glyph constants shared by the 7-segment scan driver
package seg7_pkg;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    // All glyphs are active-low: a 0 bit lights the segment.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    localparam logic [6:0] SEG_DIGIT [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD/hex to active-low segment lookup; SEG7_HEX_EN enables A-F glyphs
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_DIGIT[code];
`ifdef SEG7_HEX_EN
        segments = SEG_DIGIT[code];
`else
        if (code > 4'd9) begin
            segments = SEG_DASH;
        end
`endif
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - Multiplexed N-digit 7-segment scanner with frame-synchronous double buffer
// Optional hex glyphs for codes 10-15 via SEG7_HEX_EN (handled in seg7_decode).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int SCAN_DIV    = 1000,
    parameter int DEAD_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_bcd,
    input  logic [N_DIGITS-1:0]   i_dp,
    output logic [6:0]            o_segments,
    output logic                  o_dp_n,
    output logic [N_DIGITS-1:0]   o_digit_n,
    output logic                  o_frame
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      idx;
    logic [4*N_DIGITS-1:0] staging;
    logic [N_DIGITS-1:0]   staging_dp;
    logic [4*N_DIGITS-1:0] display;
    logic [N_DIGITS-1:0]   display_dp;
    logic                  pending;

    logic                  slot_end;
    logic                  last_idx;
    logic                  wrap;
    logic                  in_dead;
    logic [3:0]            cur_code;
    logic [6:0]            cur_seg;
    logic [N_DIGITS-1:0]   cur_onehot;

    assign slot_end = (cnt == CNT_W'(SCAN_DIV - 1));
    assign last_idx = (idx == IDX_W'(N_DIGITS - 1));
    assign wrap     = i_enable && slot_end && last_idx;

    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = ({1'b0, cnt} < (CNT_W + 1)'(DEAD_CYCLES));
        end
    endgenerate

    assign cur_code   = display[{idx, 2'b00} +: 4];
    assign cur_onehot = N_DIGITS'(1) << idx;

    seg7_decode u_decode (
        .code     (cur_code),
        .segments (cur_seg)
    );

    // Scan position and registered pin drive; pins reflect the (cnt, idx) state of the previous cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            o_segments <= SEG_BLANK;
            o_dp_n     <= 1'b1;
            o_digit_n  <= '1;
            o_frame    <= 1'b0;
        end else begin
            o_frame <= wrap;
            if (!i_enable) begin
                cnt        <= '0;
                idx        <= '0;
                o_segments <= SEG_BLANK;
                o_dp_n     <= 1'b1;
                o_digit_n  <= '1;
            end else begin
                if (slot_end) begin
                    cnt <= '0;
                    idx <= last_idx ? '0 : idx + IDX_W'(1);
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (in_dead) begin
                    o_segments <= SEG_BLANK;
                    o_dp_n     <= 1'b1;
                    o_digit_n  <= '1;
                end else begin
                    o_segments <= cur_seg;
                    o_dp_n     <= ~display_dp[idx];
                    o_digit_n  <= ~cur_onehot;
                end
            end
        end
    end

    // Double buffer: a load that coincides with a wrap re-arms pending after the old staging commits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            staging    <= '0;
            staging_dp <= '0;
            display    <= '0;
            display_dp <= '0;
            pending    <= 1'b0;
        end else if (!i_enable) begin
            if (i_load) begin
                staging    <= i_bcd;
                staging_dp <= i_dp;
                display    <= i_bcd;
                display_dp <= i_dp;
                pending    <= 1'b0;
            end
        end else begin
            if (wrap && pending) begin
                display    <= staging;
                display_dp <= staging_dp;
                pending    <= 1'b0;
            end
            if (i_load) begin
                staging    <= i_bcd;
                staging_dp <= i_dp;
                pending    <= 1'b1;
            end
        end
    end

endmodule
